alu_ctrl_pipe: RTL
==================

Name: alu_ctrl_pipe

Overview:
- Parametrised next-generation ALU control unit for the 5-stage MIPS core.
- Decodes ALUOp/Funct in decode and registers the control word into execute (D/E stage register for control).
- Adds the extended R-type set (xor, nor, shifts, sltu) and a sequencer for multi-cycle mult/div.
- The sequencer covers the HI/LO write handshake and the decode-stall hazard on mfhi/mflo.

Parameters:
- CTRL_W, 4: width of the ALU control word. Must be >= 4; bits above [3] are driven 0.
- EXT_EN, 1: 1 enables the extended ops. 0 maps xor/nor/sll/srl/sra/sltu to ADD.
- MUL_LAT, 4: execute cycles for mult/multu. Range 1..255.
- DIV_LAT, 32: execute cycles for div/divu. Range 1..255.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_d  in  1  decode holds a valid instruction.
- funct_d  in  6  instruction Funct field.
- alu_op_d  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 treated as add.
- flush_e  in  1  bubble the execute-stage control.
- alu_control_e  out  CTRL_W  registered ALU control for execute.
- valid_e  out  1  registered valid for execute.
- md_start_e  out  1  one-cycle start pulse to the mult/div unit.
- md_div_e  out  1  1 = divide, 0 = multiply; valid with md_start_e.
- md_signed_e  out  1  1 = signed (mult/div), 0 = multu/divu; valid with md_start_e.
- hilo_we  out  1  one-cycle HI/LO write enable at completion.
- md_busy  out  1  sequencer in BUSY.
- stall_d  out  1  hold the decode stage (hazard).

Behaviour:
- Control codes, CTRL_W=4:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111.
  - SLL 1000, SRL 1001, SRA 1010, SLTU 1111.
- Decode, combinational:
  - alu_op 00 or 11 -> ADD; 01 -> SUB.
  - alu_op 10: funct 100000/100001 -> ADD; 100010/100011 -> SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU; 000000 SLL; 000010 SRL; 000011 SRA.
  - All other funct -> ADD, including mult/div/mfhi/mflo.
- md op: valid_d & alu_op 10 & funct in {011000 mult, 011001 multu, 011010 div, 011011 divu}.
- hilo read: same qualifier with funct in {010000 mfhi, 010010 mflo}.
- stall_d (combinational) = md_busy & (md op | hilo read). Other instructions never stall.
- Stage register, each rising edge:
  - rst: alu_control_e = ADD, valid_e = 0. Async, immediate.
  - flush_e = 1: alu_control_e = ADD, valid_e = 0. flush_e has priority over the stall bubble.
  - stall_d = 1: insert a bubble, same values as flush.
  - otherwise: alu_control_e = decoded code, valid_e = valid_d.
- Sequencer FSM: IDLE, BUSY. 8-bit down-counter cnt.
- IDLE:
  - Accepts an md op at the rising edge when not flushed.
  - That edge sets md_start_e = 1 for the next cycle only, latches md_div_e/md_signed_e from funct[1]/~funct[0], loads cnt = LAT-1, and goes to BUSY.
  - md ops that are flushed in the same cycle are dropped.
- BUSY:
  - cnt decrements each cycle.
  - hilo_we = 1 (Moore) in the BUSY cycle where cnt == 0; BUSY -> IDLE at the end of that cycle.
  - An accepted op yields exactly LAT cycles of md_busy = 1, with hilo_we high on the last.
- md_div_e and md_signed_e hold their value until the next accept.
- Boundary cases:
  - LAT = 1: one BUSY cycle, in which both md_start_e and hilo_we are 1.
  - An md op presented in the final BUSY cycle stalls once and is accepted on the following edge. There is no back-to-back overlap.
  - flush_e during BUSY does not abort the sequencer; the op is already committed.
- Reset values: all outputs 0 except alu_control_e = ADD. FSM = IDLE, cnt = 0. Reset mid-BUSY aborts the op and produces no hilo_we.

Test Plan:
- Reset then R-type funct 100110, then 100111, then 000011 (EXT_EN=1) -> alu_control_e 0011, 0100, 1010 one cycle later. With EXT_EN=0 the same stimulus gives 0010.
- alu_op 00, 01, 11 with random funct -> 0010, 0110, 0010. Unknown R-type funct 111111 -> 0010.
- mult accepted at edge N (MUL_LAT=4) -> md_start_e=1, md_div_e=0, md_signed_e=1 in cycle N+1; md_busy cycles N+1..N+4; hilo_we only in N+4.
- mflo, then add, presented during a divu (DIV_LAT=32) -> stall_d=1 and a bubble (valid_e=0, alu_control_e=0010) for mflo until done; add passes with stall_d=0; mflo issues the cycle after hilo_we.
- rst asserted mid-BUSY at cnt=10 -> outputs cleared immediately, hilo_we never pulses; flush_e concurrent with a new mult in IDLE -> no md_start_e.
- MUL_LAT=1 with back-to-back mult, mult -> first: md_start_e and hilo_we in the same cycle; second: stalled one cycle, then accepted.

Source files
------------

// File: rtl/alu_ctrl_pipe_if.sv
// Decode-to-execute control bus of the ALU control unit, including the
// mult/div sequencer handshake and the decode stall back to the front end.
interface alu_ctrl_pipe_if #(
    parameter int unsigned CTRL_W = 4
);
    logic              valid_d;
    logic [5:0]        funct_d;
    logic [1:0]        alu_op_d;
    logic              flush_e;
    logic [CTRL_W-1:0] alu_control_e;
    logic              valid_e;
    logic              md_start_e;
    logic              md_div_e;
    logic              md_signed_e;
    logic              hilo_we;
    logic              md_busy;
    logic              stall_d;

    modport master (
        output valid_d, funct_d, alu_op_d, flush_e,
        input  alu_control_e, valid_e, md_start_e, md_div_e, md_signed_e,
               hilo_we, md_busy, stall_d
    );

    modport slave (
        input  valid_d, funct_d, alu_op_d, flush_e,
        output alu_control_e, valid_e, md_start_e, md_div_e, md_signed_e,
               hilo_we, md_busy, stall_d
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// ALU control decode with D/E control register and a multi-cycle mult/div
// sequencer that owns the HI/LO write and the mfhi/mflo decode stall.
module alu_ctrl_pipe #(
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned EXT_EN  = 1,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_ctrl_pipe_if.slave   bus
);
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_NOR  = 4'b0100;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_SLTU = 4'b1111;

    localparam logic       EXT_ON  = (EXT_EN != 0);
    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] code_c;
    logic       md_op_c;
    logic       hilo_rd_c;
    logic       accept_c;
    logic       busy_c;
    logic       stall_c;

    // ALU control decode; extended ops collapse to ADD when disabled
    always_comb begin
        code_c = C_ADD;
        case (bus.alu_op_d)
            2'b01: code_c = C_SUB;
            2'b10: begin
                case (bus.funct_d)
                    6'b100000, 6'b100001: code_c = C_ADD;
                    6'b100010, 6'b100011: code_c = C_SUB;
                    6'b100100:            code_c = C_AND;
                    6'b100101:            code_c = C_OR;
                    6'b101010:            code_c = C_SLT;
                    6'b100110:            code_c = EXT_ON ? C_XOR  : C_ADD;
                    6'b100111:            code_c = EXT_ON ? C_NOR  : C_ADD;
                    6'b101011:            code_c = EXT_ON ? C_SLTU : C_ADD;
                    6'b000000:            code_c = EXT_ON ? C_SLL  : C_ADD;
                    6'b000010:            code_c = EXT_ON ? C_SRL  : C_ADD;
                    6'b000011:            code_c = EXT_ON ? C_SRA  : C_ADD;
                    default:              code_c = C_ADD;
                endcase
            end
            default: code_c = C_ADD;
        endcase
    end

    assign md_op_c   = bus.valid_d && (bus.alu_op_d == 2'b10) && (bus.funct_d[5:2] == 4'b0110);
    assign hilo_rd_c = bus.valid_d && (bus.alu_op_d == 2'b10) &&
                       ((bus.funct_d == 6'b010000) || (bus.funct_d == 6'b010010));
    assign busy_c    = (state_q == BUSY);
    assign stall_c   = busy_c && (md_op_c || hilo_rd_c);

    assign bus.stall_d = stall_c;
    assign bus.md_busy = busy_c;
    assign bus.hilo_we = busy_c && (cnt_q == 8'd0);

    // Sequencer next state: a committed op always runs to completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_op_c && !bus.flush_e) begin
                    accept_c = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = bus.funct_d[1] ? DIV_CNT : MUL_CNT;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            bus.md_start_e  <= 1'b0;
            bus.md_div_e    <= 1'b0;
            bus.md_signed_e <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus.md_start_e <= accept_c;
            if (accept_c) begin
                bus.md_div_e    <= bus.funct_d[1];
                bus.md_signed_e <= ~bus.funct_d[0];
            end
        end
    end

    // D/E control register; flush and stall both inject an ADD bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_control_e <= CTRL_W'(C_ADD);
            bus.valid_e       <= 1'b0;
        end else if (bus.flush_e || stall_c) begin
            bus.alu_control_e <= CTRL_W'(C_ADD);
            bus.valid_e       <= 1'b0;
        end else begin
            bus.alu_control_e <= CTRL_W'(code_c);
            bus.valid_e       <= bus.valid_d;
        end
    end
endmodule
